nco_mc_core: RTL

//  Time-multiplexed, multi-channel NCO with quadrature output. NCH channels share one phase-accumulator datapath and one quarter-wave sine ROM.

---
 rtl/nco_mc_pkg.sv | 21 ++
 rtl/nco_qw_rom.sv | 41 ++++
 rtl/nco_mc_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/nco_mc_pkg.sv
// Shared types and constants for the multi-channel quadrature NCO.
package nco_mc_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  localparam int unsigned NCO_LAT   = 4;
  localparam int unsigned LFSR_W    = 15;
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  // x^15 + x^14 + 1 : feedback from bits 14 and 13 of a left-shifting register
  localparam logic [14:0] LFSR_TAPS = 15'h6000;
  localparam real         NCO_PI    = 3.14159265358979323846;

  // Ceiling log2, never below 1 so single-channel builds keep a 1-bit index.
  function automatic int unsigned nco_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Dual-read quarter-wave sine ROM with registered outputs; r[k] = round(A*sin((k+0.5)*pi/2^(RAW-1))).
// The table is built at elaboration.
module nco_qw_rom
  import nco_mc_pkg::*;
#(
  parameter int unsigned RAW = 10,
  parameter int unsigned MPR = 16,
  parameter string       RSF = "nco_mc_qw.hex"
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [RAW-3:0] addr_s,
  input  logic [RAW-3:0] addr_c,
  output logic [MPR-2:0] data_s,
  output logic [MPR-2:0] data_c
);

  localparam int unsigned AW    = RAW - 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam real         AMP   = real'((1 << (MPR - 1)) - 1);

  logic [MPR-2:0] mem [DEPTH];

  // Half-LSB phase offset makes the mirrored quadrants exact.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    assign mem[k] = (MPR-1)'($rtoi($floor(
                      AMP * $sin((real'(k) + 0.5) * NCO_PI / real'(1 << (RAW - 1))) + 0.5)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s <= '0;
      data_c <= '0;
    end else if (en) begin
      data_s <= mem[addr_s];
      data_c <= mem[addr_c];
    end
  end

endmodule

// File: rtl/nco_mc_core.sv
// Time-multiplexed NCH-channel quadrature NCO: shared accumulator datapath, quarter-wave ROM, 4-stage pipeline.
// Optional phase dither enabled by defining NCO_DITHER_EN.
module nco_mc_core
  import nco_mc_pkg::*;
#(
  parameter int unsigned APR = 32,
  parameter int unsigned RAW = 10,
  parameter int unsigned MPR = 16,
  parameter int unsigned NCH = 4,
  parameter string       RSF = "nco_mc_qw.hex"
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clken,
  input  logic                      cfg_wr,
  input  logic [nco_clog2(NCH)-1:0] cfg_ch,
  input  logic                      cfg_sel,
  input  logic [APR-1:0]            cfg_data,
  input  logic                      sync_i,
  output logic [MPR-1:0]            fsin_o,
  output logic [MPR-1:0]            fcos_o,
  output logic [nco_clog2(NCH)-1:0] ch_o,
  output logic                      out_valid
);

  localparam int unsigned CW = nco_clog2(NCH);
  localparam int unsigned AW = RAW - 2;

  logic [CW-1:0]  ch_cnt;
  logic           frame_start_c, frame_end_c;
  logic           sync_pend, sync_frame, sync_use_c;
  logic           cfg_hit_c;
  logic [APR-1:0] sh_inc [NCH];
  logic [APR-1:0] sh_off [NCH];
  logic [APR-1:0] sh_inc_nx [NCH];
  logic [APR-1:0] sh_off_nx [NCH];
  logic [APR-1:0] inc [NCH];
  logic [APR-1:0] off [NCH];
  logic [APR-1:0] acc [NCH];
  logic [APR-1:0] acc_nx_c;

  assign frame_start_c = clken && (ch_cnt == '0);
  assign frame_end_c   = clken && (ch_cnt == CW'(NCH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    ch_cnt <= '0;
    else if (clken)  ch_cnt <= frame_end_c ? '0 : ch_cnt + CW'(1);
  end

  // A pulse landing on the consuming frame-start cycle re-arms the latch for the next frame.
  assign sync_use_c = (ch_cnt == '0) ? sync_pend : sync_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pend  <= 1'b0;
      sync_frame <= 1'b0;
    end else begin
      sync_pend <= sync_i | (sync_pend & ~frame_start_c);
      if (frame_start_c) sync_frame <= sync_pend;
    end
  end

  assign cfg_hit_c = cfg_wr && (32'(cfg_ch) < 32'(NCH));

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sh_inc_nx[c] = sh_inc[c];
      sh_off_nx[c] = sh_off[c];
      if (cfg_hit_c && (32'(cfg_ch) == 32'(c))) begin
        if (cfg_sel) sh_off_nx[c] = cfg_data;
        else         sh_inc_nx[c] = cfg_data;
      end
    end
  end

  // Shadows commit on the last slot so every frame sees one coherent register set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_inc <= '{default: '0};
      sh_off <= '{default: '0};
      inc    <= '{default: '0};
      off    <= '{default: '0};
    end else begin
      sh_inc <= sh_inc_nx;
      sh_off <= sh_off_nx;
      if (frame_end_c) begin
        inc <= sh_inc_nx;
        off <= sh_off_nx;
      end
    end
  end

  // Stage 1: accumulate; offset travels with the sample to stay frame-coherent.
  logic [APR-1:0] s1_phase, s1_off;
  logic [CW-1:0]  s1_ch;

  assign acc_nx_c = sync_use_c ? inc[ch_cnt] : acc[ch_cnt] + inc[ch_cnt];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '{default: '0};
      s1_phase <= '0;
      s1_off   <= '0;
      s1_ch    <= '0;
    end else if (clken) begin
      acc[ch_cnt] <= acc_nx_c;
      s1_phase    <= acc_nx_c;
      s1_off      <= off[ch_cnt];
      s1_ch       <= ch_cnt;
    end
  end

  // Stage 2: offset, truncate to ROM address, resolve quadrant mirroring.
  logic [APR-1:0] phase_c;

`ifdef NCO_DITHER_EN
  localparam int unsigned DW = ((APR - RAW) < LFSR_W) ? (APR - RAW) : LFSR_W;
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   lfsr <= LFSR_SEED;
    else if (clken) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  assign phase_c = s1_phase + s1_off + APR'(lfsr[LFSR_W-1 -: DW]);
`else
  assign phase_c = s1_phase + s1_off;
`endif

  quad_e          qs_c, qc_c;
  logic [AW-1:0]  a_c;
  logic [AW-1:0]  s2_addr_s, s2_addr_c;
  logic           s2_neg_s, s2_neg_c;
  logic [CW-1:0]  s2_ch;

  assign qs_c = quad_e'(phase_c[APR-1 -: 2]);
  assign qc_c = quad_e'(phase_c[APR-1 -: 2] + 2'd1);
  assign a_c  = phase_c[APR-3 -: AW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_addr_s <= '0;
      s2_addr_c <= '0;
      s2_neg_s  <= 1'b0;
      s2_neg_c  <= 1'b0;
      s2_ch     <= '0;
    end else if (clken) begin
      s2_addr_s <= ((qs_c == Q1) || (qs_c == Q3)) ? ~a_c : a_c;
      s2_addr_c <= ((qc_c == Q1) || (qc_c == Q3)) ? ~a_c : a_c;
      s2_neg_s  <= (qs_c == Q2) || (qs_c == Q3);
      s2_neg_c  <= (qc_c == Q2) || (qc_c == Q3);
      s2_ch     <= s1_ch;
    end
  end

  // Stage 3: ROM read.
  logic [MPR-2:0] rom_s, rom_c;
  logic           s3_neg_s, s3_neg_c;
  logic [CW-1:0]  s3_ch;

  nco_qw_rom #(
    .RAW (RAW),
    .MPR (MPR),
    .RSF (RSF)
  ) u_rom (
    .clk    (clk),
    .rst_n  (reset_n),
    .en     (clken),
    .addr_s (s2_addr_s),
    .addr_c (s2_addr_c),
    .data_s (rom_s),
    .data_c (rom_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_neg_s <= 1'b0;
      s3_neg_c <= 1'b0;
      s3_ch    <= '0;
    end else if (clken) begin
      s3_neg_s <= s2_neg_s;
      s3_neg_c <= s2_neg_c;
      s3_ch    <= s2_ch;
    end
  end

  // Stage 4: sign restore; outputs only move once the pipe holds post-reset samples.
  logic [NCO_LAT-2:0] vld;
  logic [MPR-1:0]     ext_s_c, ext_c_c;

  assign ext_s_c = {1'b0, rom_s};
  assign ext_c_c = {1'b0, rom_c};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      fsin_o    <= '0;
      fcos_o    <= '0;
      ch_o      <= '0;
    end else if (clken) begin
      vld       <= {vld[NCO_LAT-3:0], 1'b1};
      out_valid <= vld[NCO_LAT-2];
      if (vld[NCO_LAT-2]) begin
        fsin_o <= s3_neg_s ? -ext_s_c : ext_s_c;
        fcos_o <= s3_neg_c ? -ext_c_c : ext_c_c;
        ch_o   <= s3_ch;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
